// File: rtl/da_pkg.sv
// Shared constants for the time-shared distributed-arithmetic scheduler.
package da_pkg;

  // Default configuration
  localparam int N_CH_DEF = 4;
  localparam int W_DEF    = 3;

  // Sequencer state encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Fixed filter coefficients for taps 0..2
  localparam logic [2:0] C0 = 3'd2;
  localparam logic [2:0] C1 = 3'd3;
  localparam logic [2:0] C2 = 3'd1;

endpackage

// File: rtl/da_lut3.sv
// Three-input DA coefficient table: output is the sum of the coefficients
// whose address bit is set. The largest entry (C0+C1+C2 = 6) fits in 3 bits.
module da_lut3
  import da_pkg::*;
(
  input  logic [2:0] addr_i,
  output logic [2:0] val_o
);

  // Partial-sum lookup for one bit-slice of the three samples
  always_comb begin
    val_o = (addr_i[0] ? C0 : 3'd0)
          + (addr_i[1] ? C1 : 3'd0)
          + (addr_i[2] ? C2 : 3'd0);
  end

endmodule

// File: rtl/da_sched.sv
// Round-robin scheduler sharing one bit-serial DA engine among N_CH channels.
// A job latches the winner's three samples, accumulates W LSB-first slices
// through the coefficient table, then publishes the result tagged by channel.
module da_sched
  import da_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W    = W_DEF,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH*W-1:0] x_in0,
  input  logic [N_CH*W-1:0] x_in1,
  input  logic [N_CH*W-1:0] x_in2,
  output logic [N_CH-1:0]   ack,
  output logic              busy,
  output logic [W+2:0]      y,
  output logic [CH_W-1:0]   y_ch,
  output logic              y_valid,
  output logic [2:0]        lut
);

  localparam int PW    = W + 3;
  localparam int CNT_W = $clog2(W + 1);

  logic [1:0]       state_q,   state_d;
  logic [CH_W-1:0]  rr_ptr_q,  rr_ptr_d;
  logic [CH_W-1:0]  win_q,     win_d;
  logic [PW-1:0]    p_q,       p_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [W-1:0]     x0_q,      x0_d;
  logic [W-1:0]     x1_q,      x1_d;
  logic [W-1:0]     x2_q,      x2_d;
  logic [N_CH-1:0]  ack_q,     ack_d;
  logic             busy_q,    busy_d;
  logic [PW-1:0]    y_q,       y_d;
  logic [CH_W-1:0]  y_ch_q,    y_ch_d;
  logic             y_valid_q, y_valid_d;
  logic [CH_W-1:0]  win_s;
  logic [2:0]       lut_s;

  // First requesting channel at or after ptr, wrapping modulo N_CH
  function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] r,
                                              input logic [CH_W-1:0] ptr);
    logic [CH_W-1:0] win;
    logic [N_CH-1:0] sh;
    logic            found;
    int              idx;
    win   = {CH_W{1'b0}};
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (int'(ptr) + i) % N_CH;
      sh  = r >> idx;
      if (!found && sh[0]) begin
        win   = CH_W'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  // Arbitration result, only consumed in IDLE
  always_comb begin
    win_s = rr_pick(req, rr_ptr_q);
  end

  da_lut3 u_lut (
    .addr_i ({x2_q[0], x1_q[0], x0_q[0]}),
    .val_o  (lut_s)
  );

  // Sequencer next-state: grant/latch, shift-accumulate, publish
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_d     = win_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    x0_d      = x0_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    ack_d     = {N_CH{1'b0}};
    y_d       = y_q;
    y_ch_d    = y_ch_q;
    y_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          win_d    = win_s;
          x0_d     = W'(x_in0 >> (int'(win_s) * W));
          x1_d     = W'(x_in1 >> (int'(win_s) * W));
          x2_d     = W'(x_in2 >> (int'(win_s) * W));
          p_d      = {PW{1'b0}};
          cnt_d    = {CNT_W{1'b0}};
          ack_d    = {{(N_CH-1){1'b0}}, 1'b1} << win_s;
          rr_ptr_d = (win_s == CH_W'(N_CH - 1)) ? {CH_W{1'b0}} : win_s + 1'b1;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        // Newest slice enters at weight 2^(W-1); earlier slices shift down
        p_d   = (p_q >> 1) + (PW'(lut_s) << (W - 1));
        x0_d  = x0_q >> 1;
        x1_d  = x1_q >> 1;
        x2_d  = x2_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        y_d       = p_q;
        y_ch_d    = win_q;
        y_valid_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset discards any job in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= {CH_W{1'b0}};
      win_q     <= {CH_W{1'b0}};
      p_q       <= {PW{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      x0_q      <= {W{1'b0}};
      x1_q      <= {W{1'b0}};
      x2_q      <= {W{1'b0}};
      ack_q     <= {N_CH{1'b0}};
      busy_q    <= 1'b0;
      y_q       <= {PW{1'b0}};
      y_ch_q    <= {CH_W{1'b0}};
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_q     <= win_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      x0_q      <= x0_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign ack     = ack_q;
  assign busy    = busy_q;
  assign y       = y_q;
  assign y_ch    = y_ch_q;
  assign y_valid = y_valid_q;
  assign lut     = lut_s;

endmodule

// File: tb/tb_da_sched.sv
// Directed bench for da_sched: table of single jobs plus hand-written
// sequences for fairness, late requests and reset in the middle of a job.
module tb_da_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [11:0] x_in0, x_in1, x_in2;
  logic [3:0]  ack;
  logic        busy;
  logic [5:0]  y;
  logic [1:0]  y_ch;
  logic        y_valid;
  logic [2:0]  lut;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [11:0] x0, x1, x2;
    int          ch;
    int          y;
    int          lut;
  } vec_t;

  vec_t tv[8];

  da_sched dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .x_in0   (x_in0),
    .x_in1   (x_in1),
    .x_in2   (x_in2),
    .ack     (ack),
    .busy    (busy),
    .y       (y),
    .y_ch    (y_ch),
    .y_valid (y_valid),
    .lut     (lut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] pk(input int ch, input int v);
    return 12'(v << (ch * 3));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    tv[0] = '{4'b0100, pk(2,1), pk(2,2), pk(2,3), 2, 11, 3};
    tv[1] = '{4'b0001, pk(0,7), pk(0,7), pk(0,7), 0, 42, 6};
    tv[2] = '{4'b0001, pk(0,0), pk(0,0), pk(0,0), 0, 0, 0};
    tv[3] = '{4'b1000, pk(3,5), pk(3,1), pk(3,2), 3, 15, 5};
    tv[4] = '{4'b1010, pk(1,4)|pk(3,7), pk(1,6)|pk(3,7), pk(1,1)|pk(3,7), 1, 27, 1};
    tv[5] = '{4'b1010, pk(3,3)|pk(1,7), pk(3,3)|pk(1,7), pk(3,3)|pk(1,7), 3, 18, 6};
    tv[6] = '{4'b0110, pk(2,5), pk(1,7)|pk(2,5), pk(2,5), 1, 21, 3};
    tv[7] = '{4'b0011, pk(0,6)|pk(1,7), pk(1,7), pk(0,5)|pk(1,7), 0, 17, 1};

    reset = 1'b0;
    req   = 4'b0000;
    x_in0 = 12'd0;
    x_in1 = 12'd0;
    x_in2 = 12'd0;
    step(3);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_y_ch", 32'(y_ch), 32'd0);
    chk("rst_y_valid", 32'(y_valid), 32'd0);
    chk("rst_lut", 32'(lut), 32'd0);
    reset = 1'b1;
    step(2);
    chk("idle_busy", 32'(busy), 32'd0);

    // Table of single jobs, each started from IDLE
    for (int v = 0; v < 8; v++) begin
      req   = tv[v].req;
      x_in0 = tv[v].x0;
      x_in1 = tv[v].x1;
      x_in2 = tv[v].x2;
      wait_ack($sformatf("v%0d_ack_seen", v));
      chk($sformatf("v%0d_ack", v), 32'(ack), 32'(4'b0001 << tv[v].ch));
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
      chk($sformatf("v%0d_lut", v), 32'(lut), 32'(tv[v].lut));
      req = 4'b0000;
      step(1);
      chk($sformatf("v%0d_ack_pulse", v), 32'(ack), 32'd0);
      chk($sformatf("v%0d_early_valid", v), 32'(y_valid), 32'd0);
      step(3);
      chk($sformatf("v%0d_valid", v), 32'(y_valid), 32'd1);
      chk($sformatf("v%0d_y", v), 32'(y), 32'(tv[v].y));
      chk($sformatf("v%0d_y_ch", v), 32'(y_ch), 32'(tv[v].ch));
      step(1);
      chk($sformatf("v%0d_valid_pulse", v), 32'(y_valid), 32'd0);
      chk($sformatf("v%0d_busy_low", v), 32'(busy), 32'd0);
      chk($sformatf("v%0d_y_hold", v), 32'(y), 32'(tv[v].y));
    end

    // Reset during RUN: job dropped, pointer back to channel 0
    req   = 4'b0100;
    x_in0 = pk(2,7);
    x_in1 = pk(2,7);
    x_in2 = pk(2,7);
    wait_ack("mr_ack_seen");
    chk("mr_ack", 32'(ack), 32'b0100);
    req = 4'b0000;
    step(2);
    reset = 1'b0;
    #1;
    chk("mr_ack0", 32'(ack), 32'd0);
    chk("mr_busy0", 32'(busy), 32'd0);
    chk("mr_y0", 32'(y), 32'd0);
    chk("mr_y_ch0", 32'(y_ch), 32'd0);
    chk("mr_valid0", 32'(y_valid), 32'd0);
    chk("mr_lut0", 32'(lut), 32'd0);
    step(2);
    reset = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        step(1);
        if (y_valid) seen++;
      end
      chk("mr_no_valid", 32'(seen), 32'd0);
    end
    req   = 4'b1010;
    x_in0 = pk(1,1) | pk(3,7);
    x_in1 = pk(1,1) | pk(3,7);
    x_in2 = pk(1,1) | pk(3,7);
    wait_ack("mr_next_seen");
    chk("mr_next_ack", 32'(ack), 32'b0010);
    req = 4'b0000;
    step(4);
    chk("mr_next_valid", 32'(y_valid), 32'd1);
    chk("mr_next_y", 32'(y), 32'd6);
    chk("mr_next_y_ch", 32'(y_ch), 32'd1);
    step(1);

    // Fresh pointer, then all four channels requesting continuously
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(1);
    req   = 4'b1111;
    x_in0 = {3'd4, 3'd3, 3'd2, 3'd1};
    x_in1 = {3'd3, 3'd2, 3'd1, 3'd0};
    x_in2 = {3'd1, 3'd1, 3'd1, 3'd1};
    wait_ack("fair_seen");
    for (int j = 0; j < 5; j++) begin
      int c;
      int ey;
      c  = j % 4;
      ey = 2 * (c + 1) + 3 * c + 1;
      chk($sformatf("fair%0d_ack", j), 32'(ack), 32'(4'b0001 << c));
      if (j == 4) req = 4'b0000;
      step(4);
      chk($sformatf("fair%0d_valid", j), 32'(y_valid), 32'd1);
      chk($sformatf("fair%0d_y_ch", j), 32'(y_ch), 32'(c));
      chk($sformatf("fair%0d_y", j), 32'(y), 32'(ey));
      step(1);
    end
    chk("fair_end_busy", 32'(busy), 32'd0);
    chk("fair_end_ack", 32'(ack), 32'd0);

    // Request raised during RUN waits for the next IDLE
    req   = 4'b0001;
    x_in0 = pk(0,2) | pk(1,1);
    x_in1 = pk(0,2) | pk(1,1);
    x_in2 = pk(0,2) | pk(1,1);
    wait_ack("late_seen");
    chk("late_ack0", 32'(ack), 32'b0001);
    req = 4'b0000;
    step(1);
    req = 4'b0010;
    chk("late_k1", 32'(ack), 32'd0);
    step(1);
    chk("late_k2", 32'(ack), 32'd0);
    step(1);
    chk("late_k3", 32'(ack), 32'd0);
    step(1);
    chk("late_k4_ack", 32'(ack), 32'd0);
    chk("late_k4_valid", 32'(y_valid), 32'd1);
    chk("late_k4_y", 32'(y), 32'd12);
    chk("late_k4_y_ch", 32'(y_ch), 32'd0);
    step(1);
    chk("late_k5_ack", 32'(ack), 32'b0010);
    req = 4'b0000;
    step(4);
    chk("late2_valid", 32'(y_valid), 32'd1);
    chk("late2_y", 32'(y), 32'd6);
    chk("late2_y_ch", 32'(y_ch), 32'd1);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
